up_sample_sched: RTL and testbench

UP_SAMPLE_SCHED -- requirements
Module: up_sample_sched

---
 rtl/up_sample_sched_pkg.sv | 25 ++
 rtl/up_sample_sched_cnt2d.sv | 54 +++++
 rtl/up_sample_sched.sv | 151 +++++++++++++++
 tb/tb_up_sample_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_sample_sched_pkg.sv
// -----------------------------------------------------------------------------
// up_sample_sched_pkg
// Shared types and constants for the 2x nearest-neighbour up-sample scheduler.
//   state_t        : scheduler FSM states
//   CTRL_W         : width of one loop index (ctrl var)
//   NUM_CTRL_VARS  : number of loop indices per port ([0]=0, [1]=row, [2]=col)
// -----------------------------------------------------------------------------
package up_sample_sched_pkg;

  localparam int unsigned CTRL_W        = 16;
  localparam int unsigned NUM_CTRL_VARS = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_UPSAMPLE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // True when a dimension fits a CTRL_W-bit unsigned counter after doubling.
  function automatic bit dim_ok(input int unsigned dim);
    return (dim >= 1) && (2 * dim <= 32768);
  endfunction

endpackage

// File: rtl/up_sample_sched_cnt2d.sv
// -----------------------------------------------------------------------------
// up_sample_sched_cnt2d
// 2-D wrapping index counter: col runs 0..COLS-1, row increments when col
// wraps, and the whole counter wraps to (0,0) after (ROWS-1, COLS-1).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to (0,0), dominates inc
//   inc      : advance by one position
//   row, col : current index (registered)
//   last     : current index is (ROWS-1, COLS-1)
// -----------------------------------------------------------------------------
module up_sample_sched_cnt2d
  import up_sample_sched_pkg::*;
#(
  parameter int unsigned COLS = 64,
  parameter int unsigned ROWS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [CTRL_W-1:0] row,
  output logic [CTRL_W-1:0] col,
  output logic              last
);

  localparam logic [CTRL_W-1:0] COL_MAX = CTRL_W'(COLS - 1);
  localparam logic [CTRL_W-1:0] ROW_MAX = CTRL_W'(ROWS - 1);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap = (col == COL_MAX);
  assign row_wrap = (row == ROW_MAX);
  assign last     = col_wrap && row_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + CTRL_W'(1);
      end else begin
        col <= col + CTRL_W'(1);
      end
    end
  end

endmodule

// File: rtl/up_sample_sched.sv
// -----------------------------------------------------------------------------
// up_sample_sched
// Schedules one frame of 2x nearest-neighbour up-sampling: loads an
// IMG_W x IMG_H input image into the stencil buffer, then reads out a
// 2*IMG_W x 2*IMG_H image, then pulses done.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : synchronous abort to IDLE (highest priority)
//   start            : begin one frame (honoured in IDLE only)
//   in_valid/in_ready: input pixel handshake
//   wr_wen           : stencil buffer write enable
//   wr_ctrl_vars     : write indices {col, row, 0}
//   out_ready        : downstream accepts an output pixel
//   rd_ren/out_valid : read enable / output pixel valid
//   rd_ctrl_vars     : read indices {out_col, out_row, 0}
//   busy, done       : frame in progress / one-cycle completion pulse
//
// state       | meaning
// ST_IDLE     | waiting for start, all enables low
// ST_LOAD     | accepting input pixels into the stencil buffer
// ST_UPSAMPLE | issuing reads for every output pixel
// ST_DONE     | one-cycle completion pulse, back to IDLE
// -----------------------------------------------------------------------------
module up_sample_sched
  import up_sample_sched_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 wr_wen,
  output logic [NUM_CTRL_VARS-1:0][CTRL_W-1:0] wr_ctrl_vars,
  input  logic                                 out_ready,
  output logic                                 rd_ren,
  output logic [NUM_CTRL_VARS-1:0][CTRL_W-1:0] rd_ctrl_vars,
  output logic                                 out_valid,
  output logic                                 busy,
  output logic                                 done
);

  if (!dim_ok(IMG_W) || !dim_ok(IMG_H)) begin : g_param_check
    $error("up_sample_sched: IMG_W/IMG_H must be >= 1 and 2*dim <= 32768");
  end

  state_t            state;
  state_t            state_nxt;
  logic              cnt_clr;
  logic              wr_last;
  logic              rd_last;
  logic [CTRL_W-1:0] wr_row;
  logic [CTRL_W-1:0] wr_col;
  logic [CTRL_W-1:0] rd_row;
  logic [CTRL_W-1:0] rd_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush blocks the handshakes in its own cycle so that no transfer is
  // signalled that the cleared counters would not account for.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    in_ready  = 1'b0;
    wr_wen    = 1'b0;
    rd_ren    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = !flush;
        wr_wen   = in_valid && !flush;
        if (wr_wen && wr_last) begin
          state_nxt = ST_UPSAMPLE;
        end
      end
      ST_UPSAMPLE: begin
        busy      = 1'b1;
        rd_ren    = out_ready && !flush;
        out_valid = rd_ren;
        if (rd_ren && rd_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
    end
  end

  up_sample_sched_cnt2d #(
    .COLS (IMG_W),
    .ROWS (IMG_H)
  ) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (wr_wen),
    .row  (wr_row),
    .col  (wr_col),
    .last (wr_last)
  );

  up_sample_sched_cnt2d #(
    .COLS (2 * IMG_W),
    .ROWS (2 * IMG_H)
  ) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (rd_ren),
    .row  (rd_row),
    .col  (rd_col),
    .last (rd_last)
  );

  assign wr_ctrl_vars[0] = '0;
  assign wr_ctrl_vars[1] = wr_row;
  assign wr_ctrl_vars[2] = wr_col;
  assign rd_ctrl_vars[0] = '0;
  assign rd_ctrl_vars[1] = rd_row;
  assign rd_ctrl_vars[2] = rd_col;

endmodule

// File: tb/tb_up_sample_sched.sv
// -----------------------------------------------------------------------------
// tb_up_sample_sched
// Self-checking bench for up_sample_sched with IMG_W = IMG_H = 4.
// The reference model tracks frame progress as plain write/read counts and
// derives the expected indices arithmetically from them.
// -----------------------------------------------------------------------------
module tb_up_sample_sched;

  localparam int W = 4;
  localparam int H = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             wr_wen;
  logic [2:0][15:0] wr_ctrl_vars;
  logic             out_ready;
  logic             rd_ren;
  logic [2:0][15:0] rd_ctrl_vars;
  logic             out_valid;
  logic             busy;
  logic             done;

  up_sample_sched #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_wen       (wr_wen),
    .wr_ctrl_vars (wr_ctrl_vars),
    .out_ready    (out_ready),
    .rd_ren       (rd_ren),
    .rd_ctrl_vars (rd_ctrl_vars),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ph: 0 idle, 1 load, 2 upsample, 3 done
  int ph   = 0;
  int n_wr = 0;
  int n_rd = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; n_wr = 0; n_rd = 0;
    end else if (flush) begin
      ph = 0; n_wr = 0; n_rd = 0;
    end else begin
      case (ph)
        0: if (start) begin ph = 1; n_wr = 0; n_rd = 0; end
        1: if (in_valid) begin
             n_wr++;
             if (n_wr == W * H) ph = 2;
           end
        2: if (out_ready) begin
             n_rd++;
             if (n_rd == 4 * W * H) ph = 3;
           end
        default: ph = 0;
      endcase
    end
  end

  function automatic logic [101:0] pack(input logic ir, wen, ren, ov, bz, dn,
                                        input logic [15:0] wr1, wr2, rd1, rd2);
    return {ir, wen, ren, ov, bz, dn, 16'd0, wr1, wr2, 16'd0, rd1, rd2};
  endfunction

  function automatic logic [101:0] exp_vec();
    logic ir, wen, ren;
    ir  = (ph == 1) && !flush;
    wen = ir && in_valid;
    ren = (ph == 2) && out_ready && !flush;
    return pack(ir, wen, ren, ren, (ph == 1) || (ph == 2), ph == 3,
                16'((n_wr / W) % H), 16'(n_wr % W),
                16'((n_rd / (2 * W)) % (2 * H)), 16'(n_rd % (2 * W)));
  endfunction

  function automatic logic [101:0] act_vec();
    return {in_ready, wr_wen, rd_ren, out_valid, busy, done,
            wr_ctrl_vars[0], wr_ctrl_vars[1], wr_ctrl_vars[2],
            rd_ctrl_vars[0], rd_ctrl_vars[1], rd_ctrl_vars[2]};
  endfunction

  task automatic check_model(input string nm);
    check(nm, act_vec(), exp_vec());
  endtask

  int done_seen = 0;
  always @(negedge clk) if (done) done_seen++;

  // Checks at the negedge, then moves to just after the next posedge.
  task automatic step(input string nm);
    @(negedge clk);
    check_model(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       start;
    logic       flush;
    logic       in_valid;
    logic       busy;
    logic       in_ready;
    logic       wr_wen;
    logic [15:0] row;
    logic [15:0] col;
    logic       done;
  } vec_t;

  vec_t tbl[11];

  int first_wen, last_wen, n_wen, first_ren, last_ren, n_ren, done_cyc, n_done, n_bad;
  logic [15:0] wr_first_r, wr_first_c, wr_last_r, wr_last_c;
  logic [15:0] rd_first_r, rd_first_c, rd_last_r, rd_last_c;
  logic [15:0] prev_r, prev_c;
  logic        prev_wen;
  bit          found;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st fl iv  bz ir we row col dn
    tbl[0]  = '{1, 1, 1,  0, 0, 0, 0, 0, 0};  // start+flush in IDLE
    tbl[1]  = '{0, 0, 1,  0, 0, 0, 0, 0, 0};  // still IDLE, in_valid ignored
    tbl[2]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0};  // start
    tbl[3]  = '{0, 0, 1,  1, 1, 1, 0, 0, 0};  // LOAD, first write
    tbl[4]  = '{0, 0, 0,  1, 1, 0, 0, 1, 0};  // gap holds index
    tbl[5]  = '{1, 0, 1,  1, 1, 1, 0, 1, 0};  // start in LOAD ignored
    tbl[6]  = '{0, 0, 1,  1, 1, 1, 0, 2, 0};
    tbl[7]  = '{0, 0, 1,  1, 1, 1, 0, 3, 0};
    tbl[8]  = '{0, 0, 0,  1, 1, 0, 1, 0, 0};  // col wrapped, row advanced
    tbl[9]  = '{0, 1, 1,  1, 0, 0, 1, 0, 0};  // flush beats the handshake
    tbl[10] = '{0, 0, 1,  0, 0, 0, 0, 0, 0};  // back in IDLE, cleared

    do_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs", act_vec(), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start; flush = tbl[i].flush; in_valid = tbl[i].in_valid; out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("table[%0d]", i),
            {busy, in_ready, wr_wen, wr_ctrl_vars[1], wr_ctrl_vars[2], done, wr_ctrl_vars[0]},
            {tbl[i].busy, tbl[i].in_ready, tbl[i].wr_wen, tbl[i].row, tbl[i].col, tbl[i].done, 16'd0});
      check_model("table_model");
      @(posedge clk);
      #1;
    end
    start = 1'b0; flush = 1'b0;

    // ---------------- full frame ----------------
    do_reset();
    first_wen = -1; last_wen = -1; n_wen = 0;
    first_ren = -1; last_ren = -1; n_ren = 0; done_cyc = -1; n_done = 0;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 85; c++) begin
      @(negedge clk);
      check_model("frame_model");
      if (wr_wen) begin
        if (first_wen < 0) begin first_wen = c; wr_first_r = wr_ctrl_vars[1]; wr_first_c = wr_ctrl_vars[2]; end
        last_wen = c; n_wen++; wr_last_r = wr_ctrl_vars[1]; wr_last_c = wr_ctrl_vars[2];
      end
      if (rd_ren) begin
        if (first_ren < 0) begin first_ren = c; rd_first_r = rd_ctrl_vars[1]; rd_first_c = rd_ctrl_vars[2]; end
        last_ren = c; n_ren++; rd_last_r = rd_ctrl_vars[1]; rd_last_c = rd_ctrl_vars[2];
      end
      if (done) begin done_cyc = c; n_done++; end
      @(posedge clk);
      #1 start = 1'b0;
    end
    check("frame_wen_first", first_wen, 1);
    check("frame_wen_last", last_wen, 16);
    check("frame_wen_count", n_wen, 16);
    check("frame_wr_first_idx", {wr_first_r, wr_first_c}, {16'd0, 16'd0});
    check("frame_wr_last_idx", {wr_last_r, wr_last_c}, {16'd3, 16'd3});
    check("frame_ren_first", first_ren, 17);
    check("frame_ren_last", last_ren, 80);
    check("frame_ren_count", n_ren, 64);
    check("frame_rd_first_idx", {rd_first_r, rd_first_c}, {16'd0, 16'd0});
    check("frame_rd_last_idx", {rd_last_r, rd_last_c}, {16'd7, 16'd7});
    check("frame_done_cycle", done_cyc, 81);
    check("frame_done_count", n_done, 1);

    // ---------------- gapped input, then backpressure ----------------
    do_reset();
    n_wen = 0; last_wen = -1; n_bad = 0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step("gap_start");
    start = 1'b0;
    prev_r = wr_ctrl_vars[1]; prev_c = wr_ctrl_vars[2]; prev_wen = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      in_valid = c[0];
      @(negedge clk);
      check_model("gap_model");
      if ({wr_ctrl_vars[1], wr_ctrl_vars[2]} != {prev_r, prev_c} && !prev_wen) n_bad++;
      prev_r = wr_ctrl_vars[1]; prev_c = wr_ctrl_vars[2]; prev_wen = wr_wen;
      if (wr_wen) begin n_wen++; last_wen = c; end
      @(posedge clk);
      #1;
    end
    check("gap_write_count", n_wen, 16);
    check("gap_last_write_cycle", last_wen, 31);
    check("gap_index_only_after_write", n_bad, 0);

    in_valid = 1'b0; out_ready = 1'b1; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      check_model("bp_seek_model");
      if (rd_ctrl_vars[1] == 16'd2 && rd_ctrl_vars[2] == 16'd5) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("bp_reached_2_5", found, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_stall[%0d]", k),
            {rd_ren, out_valid, rd_ctrl_vars[0], rd_ctrl_vars[1], rd_ctrl_vars[2]},
            {1'b0, 1'b0, 16'd0, 16'd2, 16'd5});
      check_model("bp_stall_model");
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume", {rd_ren, out_valid, rd_ctrl_vars[1], rd_ctrl_vars[2]},
          {1'b1, 1'b1, 16'd2, 16'd5});
    @(posedge clk);
    @(negedge clk);
    check("bp_after_resume", {rd_ctrl_vars[1], rd_ctrl_vars[2]}, {16'd2, 16'd6});
    @(posedge clk);
    #1;

    // ---------------- flush in UPSAMPLE ----------------
    do_reset();
    done_seen = 0;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      check_model("flush_seek_model");
      if (busy && !in_ready && rd_ctrl_vars[1] == 16'd3 && rd_ctrl_vars[2] == 16'd1) found = 1'b1;
      else begin @(posedge clk); #1 start = 1'b0; end
    end
    check("flush_reached_3_1", found, 1'b1);
    flush = 1'b1;
    #1 check_model("flush_cycle_model");
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {busy, done, rd_ren, rd_ctrl_vars[1], rd_ctrl_vars[2]}, '0);
    check_model("flush_idle_model");
    @(posedge clk);
    #1;
    repeat (5) step("flush_idle_hold");
    check("flush_no_done", done_seen, 0);
    start = 1'b1;
    step("flush_restart");
    start = 1'b0;
    @(negedge clk);
    check("flush_first_write", {wr_wen, wr_ctrl_vars[0], wr_ctrl_vars[1], wr_ctrl_vars[2]},
          {1'b1, 48'd0});
    @(posedge clk);
    #1;

    // ---------------- async reset mid-LOAD ----------------
    do_reset();
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step("rst_start");
    start = 1'b0;
    repeat (5) step("rst_load");
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", act_vec(), '0);
    check_model("rst_async_model");
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b1;
    step("rst_restart");
    start = 1'b0;
    @(negedge clk);
    check("rst_first_write", {wr_wen, wr_ctrl_vars[1], wr_ctrl_vars[2]}, {1'b1, 32'd0});
    @(posedge clk);
    #1;

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 249) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step("random_model");
    end
    flush = 1'b0; start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
